dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the RISC-V core's load/store port (CPU) and the keypad/LCD calculator front-end (FPGA).
- The front-end writes operands and opcode to fixed words (220/240/260) and reads the result word (280).
- The arbiter serialises both requesters onto one memory port with a request/acknowledge handshake, FPGA-first priority, a starvation bound, an exclusive-lock mode and a memory timeout.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/arb_timeout_ctr.sv | 30 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end and its data-memory arbiter.
// The mailbox words are where the front-end places its operands and opcode, and where it reads the result.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER_CPU  = 2'd1,
        XFER_FPGA = 2'd2,
        ACK       = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_FPGA = 2'b10;

    localparam logic [31:0] OP1_ADDR = 32'd220;
    localparam logic [31:0] OP2_ADDR = 32'd240;
    localparam logic [31:0] OPC_ADDR = 32'd260;
    localparam logic [31:0] RES_ADDR = 32'd280;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable 8-bit up-counter. It flags expiry in the enabled cycle whose increment would reach the limit.
// It has no latency beyond the registered count and no backpressure.
module arb_timeout_ctr (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = en && ((count + 8'd1) == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises the CPU and the calculator front-end onto the single-port data memory, with the front-end having priority.
// A request becomes mem_req 1 cycle later; the ack pulses 1 cycle after mem_ack or timeout; requesters wait for the ack.
module dmem_arbiter
    import calc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MAX_BURST = 4,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_WORD  = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              fpga_req,
    input  logic              fpga_we,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    output logic [DATA_W-1:0] fpga_rdata,
    output logic              fpga_ack,
    input  logic              fpga_lock,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    arb_state_t        state, state_nxt;
    logic              grant_cpu, grant_fpga, burst_full;
    logic              in_xfer, tmo_en, tmo_expired;
    logic [3:0]        burst_cnt;
    logic [1:0]        owner_q;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    // The CPU wins only when the front-end has used up its burst allowance, and never while the front-end holds the lock.
    assign burst_full = (burst_cnt == 4'(MAX_BURST));
    assign grant_cpu  = (state == IDLE) && cpu_req && !fpga_lock && (!fpga_req || burst_full);
    assign grant_fpga = (state == IDLE) && fpga_req && !grant_cpu;
    assign in_xfer    = (state == XFER_CPU) || (state == XFER_FPGA);
    assign tmo_en     = in_xfer && !mem_ack;

    arb_timeout_ctr u_tmo (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (grant_cpu || grant_fpga),
        .load     (1'b0),
        .load_val (8'd0),
        .en       (tmo_en),
        .limit    (8'(TIMEOUT)),
        .expired  (tmo_expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_fpga) begin
                    state_nxt = XFER_FPGA;
                end else if (grant_cpu) begin
                    state_nxt = XFER_CPU;
                end
            end
            XFER_CPU, XFER_FPGA: begin
                if (mem_ack || tmo_expired) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = in_xfer;
        mem_we    = cap_we;
        mem_addr  = cap_addr;
        mem_wdata = cap_wdata;
        owner     = owner_q;
        cpu_ack   = (state == ACK) && (owner_q == OWN_CPU);
        fpga_ack  = (state == ACK) && (owner_q == OWN_FPGA);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            owner_q     <= OWN_NONE;
            burst_cnt   <= 4'd0;
            cpu_rdata   <= '0;
            fpga_rdata  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_cpu) begin
                cap_we    <= cpu_we;
                cap_addr  <= cpu_addr;
                cap_wdata <= cpu_wdata;
                owner_q   <= OWN_CPU;
                burst_cnt <= 4'd0;
            end else if (grant_fpga) begin
                cap_we    <= fpga_we;
                cap_addr  <= fpga_addr;
                cap_wdata <= fpga_wdata;
                owner_q   <= OWN_FPGA;
                if (!cpu_req) begin
                    burst_cnt <= 4'd0;
                end else if (!burst_full) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else if (state == ACK) begin
                owner_q <= OWN_NONE;
            end

            if (state == XFER_CPU && mem_ack) begin
                cpu_rdata <= mem_rdata;
            end else if (state == XFER_CPU && tmo_expired) begin
                cpu_rdata <= ERR_WORD;
            end

            if (state == XFER_FPGA && mem_ack) begin
                fpga_rdata <= mem_rdata;
            end else if (state == XFER_FPGA && tmo_expired) begin
                fpga_rdata <= ERR_WORD;
            end

            if (tmo_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomised checks of dmem_arbiter against a memory responder and a reference copy of memory contents.
module tb_dmem_arbiter;
    import calc_pkg::*;

    localparam int MB  = 4;
    localparam int TMO = 8;

    logic        clk, nrst;
    logic        cpu_req, cpu_we, cpu_ack, fpga_req, fpga_we, fpga_ack, fpga_lock;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, fpga_addr, fpga_wdata, fpga_rdata;
    logic        mem_req, mem_we, mem_ack, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;

    int          ack_delay = 1;
    int          req_cycles = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [1:0]  last_owner;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    dmem_arbiter #(.MAX_BURST(MB), .TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata),
        .fpga_rdata(fpga_rdata), .fpga_ack(fpga_ack), .fpga_lock(fpga_lock),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Memory: acks after ack_delay cycles of mem_req (negative = random 0..3 per access).
    initial begin : mem_responder
        int wait_cnt;
        int cur_delay;
        wait_cnt  = 0;
        cur_delay = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (wait_cnt == 0)
                    cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                req_cycles++;
                if (wait_cnt == cur_delay) begin
                    mem_ack    = 1'b1;
                    last_we    = mem_we;
                    last_addr  = mem_addr;
                    last_wdata = mem_wdata;
                    last_owner = owner;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : ~mem_addr;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    // One isolated transfer; lat counts negedges from request to the ack cycle (-1 if it never came).
    task automatic run_xfer(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output bit other);
        lat   = -1;
        rd    = '0;
        other = 1'b0;
        @(negedge clk);
        if (f) begin
            fpga_req = 1'b1; fpga_we = we; fpga_addr = a; fpga_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 2) begin
                if (f) begin fpga_addr = $urandom; fpga_wdata = $urandom; end
                else   begin cpu_addr = $urandom;  cpu_wdata = $urandom;  end
            end
            if (f ? cpu_ack : fpga_ack) other = 1'b1;
            if (f ? fpga_ack : cpu_ack) begin
                lat = n;
                rd  = f ? fpga_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req  = 1'b0;
        fpga_req = 1'b0;
    endtask

    // Records grant order from the ack pulses: bit i = 1 when the i-th ack went to the CPU.
    task automatic collect(input int n, input bit drop, output logic [31:0] order, output bit both);
        int got;
        got   = 0;
        order = '0;
        both  = 1'b0;
        for (int c = 0; c < n * 40 && got < n; c++) begin
            @(negedge clk);
            if (cpu_ack && fpga_ack) both = 1'b1;
            if (cpu_ack || fpga_ack) begin
                order[got] = cpu_ack;
                got++;
            end
        end
        if (got < n) order = 32'hFFFF_FFFF;
        if (drop) begin
            cpu_req  = 1'b0;
            fpga_req = 1'b0;
        end
    endtask

    initial begin
        int          lat, acks, bad;
        logic [31:0] rd, a, wd, order, exp_order;
        bit          other, both, f, we;

        nrst = 1'b0; fpga_lock = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fpga_req = 1'b0; fpga_we = 1'b0; fpga_addr = '0; fpga_wdata = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_owner", owner, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_fpga_ack", fpga_ack, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_fpga_rdata", fpga_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        nrst = 1'b1;

        // Front-end write alone, memory answers two cycles after mem_req.
        ack_delay = 2;
        run_xfer(1'b1, 1'b1, OP1_ADDR, 32'h123, lat, rd, other);
        ref_mem[OP1_ADDR] = 32'h123;
        chk("fw_latency", lat, 4);
        chk("fw_mem_addr", last_addr, OP1_ADDR);
        chk("fw_mem_wdata", last_wdata, 32'h123);
        chk("fw_mem_we", last_we, 1);
        chk("fw_owner", last_owner, 2'b10);
        chk("fw_no_cpu_ack", other, 0);
        @(negedge clk);
        chk("fw_ack_one_cycle", fpga_ack, 0);
        chk("fw_owner_released", owner, 0);

        // CPU read alone, same-cycle memory ack.
        mem_store[RES_ADDR] = 32'h7B;
        ref_mem[RES_ADDR]   = 32'h7B;
        ack_delay = 0;
        run_xfer(1'b0, 1'b0, RES_ADDR, 32'h0, lat, rd, other);
        chk("cr_latency", lat, 2);
        chk("cr_rdata", rd, 32'h7B);
        chk("cr_no_fpga_ack", other, 0);

        // Random isolated transfers against the reference memory contents.
        for (int i = 0; i < 24; i++) begin
            f  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 4))
                0:       a = OP1_ADDR;
                1:       a = OP2_ADDR;
                2:       a = OPC_ADDR;
                3:       a = RES_ADDR;
                default: a = 32'($urandom_range(0, 63) * 4);
            endcase
            ack_delay = int'($urandom_range(0, 4));
            run_xfer(f, we, a, wd, lat, rd, other);
            chk("rnd_latency", lat, 32'(2 + ack_delay));
            chk("rnd_owner", last_owner, f ? 2'b10 : 2'b01);
            if (we) begin
                chk("rnd_wdata", last_wdata, wd);
                ref_mem[a] = wd;
            end else begin
                chk("rnd_rdata", rd, ref_rd(a));
            end
        end

        // Both requesters held: front-end gets MB grants, then the CPU one.
        ack_delay = -1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = OP2_ADDR;
        fpga_req = 1'b1; fpga_we = 1'b0; fpga_addr = RES_ADDR;
        exp_order = '0;
        for (int i = 0; i < 10; i++)
            if ((i + 1) % (MB + 1) == 0) exp_order[i] = 1'b1;
        collect(10, 1'b1, order, both);
        chk("contention_order", order, exp_order);
        chk("contention_no_dual_ack", both, 0);

        // Lock blocks the CPU completely; releasing it grants the CPU at the next decision.
        ack_delay = 1;
        fpga_lock = 1'b1;
        cpu_req   = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || owner !== 2'b00) bad++;
        end
        chk("lock_no_grant", bad, 0);
        fpga_lock = 1'b0;
        @(negedge clk);
        chk("unlock_mem_req", mem_req, 1);
        chk("unlock_owner", owner, 2'b01);
        collect(1, 1'b0, order, both);
        chk("unlock_cpu_ack", order, 1);
        fpga_lock = 1'b1;
        fpga_req  = 1'b1;
        collect(6, 1'b0, order, both);
        chk("lock_fpga_only", order, 0);
        fpga_lock = 1'b0;
        collect(1, 1'b1, order, both);
        chk("burst_saturated_cpu_next", order, 1);

        // Memory never answers: timeout after TMO cycles of mem_req.
        ack_delay  = 100000;
        req_cycles = 0;
        run_xfer(1'b1, 1'b0, RES_ADDR, 32'h0, lat, rd, other);
        chk("to_latency", lat, TMO + 1);
        chk("to_req_cycles", req_cycles, TMO);
        chk("to_mem_req_low", mem_req, 0);
        chk("to_rdata", rd, 32'hDEAD_BEEF);
        chk("to_err_set", timeout_err, 1);
        ack_delay = 1;
        wd = $urandom;
        run_xfer(1'b0, 1'b1, OP2_ADDR, wd, lat, rd, other);
        ref_mem[OP2_ADDR] = wd;
        chk("to_after_latency", lat, 3);
        chk("to_err_sticky", timeout_err, 1);

        // Reset in the middle of a CPU transfer.
        ack_delay = 5;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = OP1_ADDR;
        @(negedge clk);
        chk("rx_in_xfer", mem_req, 1);
        chk("rx_owner_cpu", owner, 2'b01);
        nrst = 1'b0;
        #1;
        chk("rx_mem_req", mem_req, 0);
        chk("rx_owner", owner, 0);
        chk("rx_cpu_ack", cpu_ack, 0);
        chk("rx_timeout_err", timeout_err, 0);
        chk("rx_cpu_rdata", cpu_rdata, 0);
        chk("rx_mem_addr", mem_addr, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || fpga_ack) acks++;
        end
        chk("rx_no_ack", acks, 0);
        ack_delay = 1;
        wd = $urandom;
        run_xfer(1'b0, 1'b1, OPC_ADDR, wd, lat, rd, other);
        chk("rx_next_latency", lat, 3);
        chk("rx_next_addr", last_addr, OPC_ADDR);
        chk("rx_next_wdata", last_wdata, wd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
